digit_serial_rca: RTL and testbench

- Parametrised, multi-cycle ripple-carry adder for the adder/multiplier library.
- Adds two N-bit operands plus carry-in, K bits per clock, with one K-bit ripple stage reused over N/K cycles.
- Uses a start/busy/done handshake and supports unsigned and two's-complement overflow reporting.
- Low-area alternative to the combinational N-bit RCA, and the accumulate stage for sequential multipliers.

---
 rtl/digit_serial_rca.sv | 97 +++++++++
 tb/tb_digit_serial_rca.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/digit_serial_rca.sv
// digit_serial_rca: N-bit ripple-carry adder that reuses one K-bit stage over N/K cycles.
module digit_serial_rca #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    input  logic         signed_mode,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         Ovf
);
    localparam int D  = N / K;
    localparam int CW = D > 1 ? $clog2(D) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
    logic          c_q, c_d, sm_q, sm_d, co_q, co_d, ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [K:0]    dadd;
    logic          last, accept;
    // Operands shift right one digit per cycle; the sum fills in from the top.
    always_comb begin
        dadd    = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, c_q};
        last    = cnt_q == CW'(D - 1);
        accept  = start && state_q != RUN;
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sm_d    = sm_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        if (accept) begin
            state_d = RUN;
            a_d     = A;
            b_d     = B;
            c_d     = Ci;
            sm_d    = signed_mode;
            cnt_d   = '0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            a_d   = a_q >> K;
            b_d   = b_q >> K;
            c_d   = dadd[K];
            sum_d = (sum_q >> K) | (N'(dadd[K-1:0]) << (N - K));
            cnt_d = last ? cnt_q : cnt_q + 1'b1;
            if (last) begin
                state_d = DONE;
                s_d     = sum_d;
                co_d    = dadd[K];
                // carry into the MSB is recovered as a^b^sum at that bit
                ovf_d   = sm_q ? dadd[K] ^ a_q[K-1] ^ b_q[K-1] ^ dadd[K-1] : dadd[K];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sm_q    <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sm_q    <= sm_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign S    = s_q;
    assign Co   = co_q;
    assign Ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_rca.sv
// tb_digit_serial_rca: directed and back-to-back random checks of the digit-serial adder (N=16, K=4).
module tb_digit_serial_rca;
    logic        clk = 1'b0;
    logic        rst_n, start, Ci, signed_mode;
    logic [15:0] A, B;
    logic        busy, done, Co, Ovf;
    logic [15:0] S;
    int          checks = 0;
    int          failures = 0;
    int          lat, bc, dcnt;
    logic [15:0] ea, eb;
    logic        eci, esm;
    logic [16:0] full;

    digit_serial_rca #(.N(16), .K(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Ci(Ci),
        .signed_mode(signed_mode), .busy(busy), .done(done), .S(S), .Co(Co), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sm);
        A = a; B = b; Ci = ci; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done, bounded.
    task automatic wait_done(output int l, output int nb);
        l = 0; nb = 0;
        @(negedge clk);
        while (!done && l < 20) begin
            nb += int'(busy);
            @(negedge clk);
            l++;
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] s, input logic co, input logic ovf);
        check({tag, "_S"}, 32'(S), 32'(s));
        check({tag, "_Co"}, 32'(Co), 32'(co));
        check({tag, "_Ovf"}, 32'(Ovf), 32'(ovf));
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sm,
                         output logic [15:0] s, output logic co, output logic ovf);
        full = {1'b0, a} + {1'b0, b} + 17'(ci);
        s    = full[15:0];
        co   = full[16];
        ovf  = sm ? (a[15] == b[15] && full[15] != a[15]) : full[16];
    endtask

    initial begin
        logic [15:0] xs;
        logic        xco, xovf;
        rst_n = 1'b0; start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Ci = 1'b1; signed_mode = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_res("reset", 16'h0000, 1'b0, 1'b0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);

        @(negedge clk);
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat, bc);
        check("wrap_latency", 32'(lat), 4);
        check("wrap_busy_cycles", 32'(bc), 4);
        check("wrap_busy_at_done", 32'(busy), 0);
        check_res("wrap", 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 0);

        launch(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_done(lat, bc);
        check("sovf_latency", 32'(lat), 4);
        check_res("sovf", 16'h8000, 1'b0, 1'b1);

        @(negedge clk);
        launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        wait_done(lat, bc);
        check_res("sneg", 16'hFFFF, 1'b1, 1'b0);

        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; Ci = 1'b1; start = 1'b1;
        check("iso_hold_S", 32'(S), 32'h0000FFFF);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("iso_hold_S_run", 32'(S), 32'h0000FFFF);
        check("iso_busy", 32'(busy), 1);
        wait_done(lat, bc);
        check("iso_latency", 32'(lat), 2);
        check_res("iso", 16'h5555, 1'b0, 1'b0);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        check("iso_single_done", 32'(dcnt), 0);

        launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_res("midrst", 16'h0000, 1'b0, 1'b0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        check("midrst_no_done", 32'(dcnt), 0);
        launch(16'h0002, 16'h0003, 1'b1, 1'b0);
        wait_done(lat, bc);
        check("post_rst_latency", 32'(lat), 4);
        check_res("post_rst", 16'h0006, 1'b0, 1'b0);

        @(negedge clk);
        ea = 16'($urandom); eb = 16'($urandom); eci = 1'($urandom); esm = 1'($urandom);
        launch(ea, eb, eci, esm);
        for (int i = 0; i < 500; i++) begin
            A = 16'($urandom); B = 16'($urandom); Ci = 1'($urandom); signed_mode = 1'($urandom);
            wait_done(lat, bc);
            check("b2b_latency", 32'(lat), 4);
            model(ea, eb, eci, esm, xs, xco, xovf);
            check_res("b2b", xs, xco, xovf);
            if (i < 499) begin
                ea = 16'($urandom); eb = 16'($urandom); eci = 1'($urandom); esm = 1'($urandom);
                launch(ea, eb, eci, esm);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
